// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for the data-memory interface.
//
// Takes one operation at a time from EX (valid/ready handshake), drives the
// memory strobes until the memory reports ready, and hands results to
// writeback. Non-memory ALU results pass straight through to writeback, so
// every operation leaves this stage the same way.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   ex_valid / ex_ready  operation handshake from EX (ready only in IDLE)
//   ex_mem_read/_write   operation kind (both set = illegal)
//   ex_addr, ex_wdata    address or pass-through value, store data
//   ex_rd                destination register
//   mem_read/mem_write   memory strobes, held for the whole access
//   mem_addr/mem_wdata   latched address and store data
//   mem_rdata/mem_ready  memory response
//   wb_valid/wb_rd/wb_data  one-cycle writeback pulse
//   stall                pipeline stall request (not IDLE)
//   err                  one-cycle pulse on illegal op or timeout

module mem_access_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned RD_W    = 6,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [RD_W-1:0]   ex_rd,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              err
);

  // TIMEOUT-1 is the largest value the counter ever holds.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [RD_W-1:0] rd_q;

  // Both derive straight from the state register, so they stay glitch-free.
  assign ex_ready = (state_q == StIdle);
  assign stall    = (state_q != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rd_q      <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      // Writeback and error are single-cycle pulses.
      wb_valid <= 1'b0;
      err      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ex_valid) begin
            if (ex_mem_read && ex_mem_write) begin
              err <= 1'b1;
            end else if (ex_mem_read || ex_mem_write) begin
              mem_addr  <= ex_addr;
              mem_wdata <= ex_wdata;
              rd_q      <= ex_rd;
              mem_read  <= ex_mem_read;
              mem_write <= ex_mem_write;
              cnt_q     <= '0;
              state_q   <= StAccess;
            end else begin
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              wb_data  <= DATA_W'(ex_addr);
            end
          end
        end
        StAccess: begin
          if (mem_ready) begin
            // mem_read still holds the latched op kind here.
            if (mem_read) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
              wb_data  <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state_q   <= StIdle;
          end else if (cnt_q == CntLast) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            err       <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a small wait-state memory
// model and a writeback scoreboard.

module tb_mem_access_unit;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned RD_W    = 6;
  localparam int unsigned TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid, ex_ready, ex_mem_read, ex_mem_write;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic [RD_W-1:0]   ex_rd;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ready;
  logic              wb_valid;
  logic [RD_W-1:0]   wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              stall, err;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected {wb_rd, wb_data}; error pulses counted separately.
  logic [RD_W+DATA_W-1:0] exp_q[$];
  int exp_err  = 0;
  int err_seen = 0;

  // Memory model: ready after wait_n wait cycles of an access.
  int          wait_n = 0;
  int          acc_cnt = 0;
  logic        model_ready = 1'b0;
  logic        inject_ready = 1'b0;
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];

  assign mem_ready = model_ready | inject_ready;
  assign mem_rdata = mem[mem_addr[3:0]];

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RD_W   (RD_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_mem_read (ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .ex_rd       (ex_rd),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .stall       (stall),
    .err         (err)
  );

  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      model_ready <= (acc_cnt == wait_n);
      acc_cnt     <= acc_cnt + 1;
    end else begin
      model_ready <= 1'b0;
      acc_cnt     <= 0;
    end
  end

  always @(posedge clk) begin
    if (mem_write && mem_ready) mem[mem_addr[3:0]] <= mem_wdata;
  end

  // Output monitor: pop the scoreboard on every writeback pulse.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_wb: got rd=%0d data=%0d, required none", wb_rd, wb_data);
      end else begin
        logic [RD_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({wb_rd, wb_data} !== e) begin
          errors++;
          $display("FAIL sb_wb: got rd=%0d data=%0d, required rd=%0d data=%0d",
                   wb_rd, wb_data, e[DATA_W+:RD_W], e[DATA_W-1:0]);
        end
      end
    end
    if (err === 1'b1) err_seen++;
    if (wb_valid === 1'b1 && err === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wb_err_overlap: got wb_valid=1 err=1, required not both");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one op into the unit; returns just after the accepting edge (+#1).
  task automatic issue(input logic rd_op, input logic wr_op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [5:0] rd);
    int n = 0;
    while (ex_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (ex_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL issue_ready: got ex_ready=%b, required 1 within 50 cycles", ex_ready);
    end
    ex_valid     = 1'b1;
    ex_mem_read  = rd_op;
    ex_mem_write = wr_op;
    ex_addr      = addr;
    ex_wdata     = wdata;
    ex_rd        = rd;
    @(posedge clk);
    #1;
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({mem_read, mem_write, wb_valid, err, stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got rd=%b wr=%b wbv=%b err=%b stall=%b, required all 0",
               mem_read, mem_write, wb_valid, err, stall);
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0 || wb_rd !== '0 || wb_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%0h wdata=%0h rd=%0d data=%0h, required 0",
               mem_addr, mem_wdata, wb_rd, wb_data);
    end
    checks++;
    if (ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", ex_ready);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_nonmem();
    exp_q.push_back({6'd3, 32'd28});
    issue(1'b0, 1'b0, 32'd28, 32'd0, 6'd3);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'd28 || wb_rd !== 6'd3) begin
      errors++;
      $display("FAIL nonmem_wb: got v=%b data=%0d rd=%0d, required v=1 data=28 rd=3",
               wb_valid, wb_data, wb_rd);
    end
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL nonmem_strobe: got rd=%b wr=%b ready=%b, required 0 0 1",
               mem_read, mem_write, ex_ready);
    end
    step();
  endtask

  task automatic test_store_load();
    wait_n = 0;
    issue(1'b0, 1'b1, 32'd5, 32'd18, 6'd2);
    ref_mem[5] = 32'd18;
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'd5 ||
        mem_wdata !== 32'd18 || stall !== 1'b1) begin
      errors++;
      $display("FAIL store_access: got wr=%b rd=%b addr=%0d wdata=%0d stall=%b, required 1 0 5 18 1",
               mem_write, mem_read, mem_addr, mem_wdata, stall);
    end
    step();
    checks++;
    if (mem_write !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL store_done: got wr=%b wbv=%b ready=%b, required 0 0 1",
               mem_write, wb_valid, ex_ready);
    end
    // Back-to-back: the load is accepted on the very next edge.
    exp_q.push_back({6'd7, ref_mem[5]});
    issue(1'b1, 1'b0, 32'd5, 32'd0, 6'd7);
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 32'd5) begin
      errors++;
      $display("FAIL load_access: got rd=%b addr=%0d, required 1 5", mem_read, mem_addr);
    end
    step();
    checks++;
    if (mem_read !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'd18 || wb_rd !== 6'd7) begin
      errors++;
      $display("FAIL load_wb: got rd=%b v=%b data=%0d wbrd=%0d, required 0 1 18 7",
               mem_read, wb_valid, wb_data, wb_rd);
    end
    step();
  endtask

  task automatic test_wait_states();
    wait_n = 3;
    exp_q.push_back({6'd9, ref_mem[5]});
    issue(1'b1, 1'b0, 32'd5, 32'd0, 6'd9);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_read !== 1'b1 || stall !== 1'b1 || ex_ready !== 1'b0 ||
          mem_addr !== 32'd5 || wb_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold[%0d]: got rd=%b stall=%b ready=%b addr=%0d wbv=%b, required 1 1 0 5 0",
                 i, mem_read, stall, ex_ready, mem_addr, wb_valid);
      end
      step();
    end
    checks++;
    if (mem_read !== 1'b0 || wb_valid !== 1'b1 || wb_rd !== 6'd9) begin
      errors++;
      $display("FAIL wait_done: got rd=%b wbv=%b wbrd=%0d, required 0 1 9",
               mem_read, wb_valid, wb_rd);
    end
    step();
  endtask

  task automatic test_timeout();
    wait_n = 1000;
    exp_err++;
    issue(1'b1, 1'b0, 32'd3, 32'd0, 6'd4);
    for (int i = 0; i < int'(TIMEOUT); i++) begin
      checks++;
      if (mem_read !== 1'b1 || err !== 1'b0) begin
        errors++;
        $display("FAIL timeout_hold[%0d]: got rd=%b err=%b, required 1 0", i, mem_read, err);
      end
      step();
    end
    checks++;
    if (mem_read !== 1'b0 || err !== 1'b1 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: got rd=%b err=%b wbv=%b ready=%b, required 0 1 0 1",
               mem_read, err, wb_valid, ex_ready);
    end
    step();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%b, required 0", err);
    end
  endtask

  task automatic test_illegal();
    exp_err++;
    issue(1'b1, 1'b1, 32'd9, 32'd1, 6'd5);
    checks++;
    if (err !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
        wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal: got err=%b rd=%b wr=%b wbv=%b ready=%b, required 1 0 0 0 1",
               err, mem_read, mem_write, wb_valid, ex_ready);
    end
    step();
    checks++;
    if (err !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL illegal_after: got err=%b rd=%b wr=%b, required 0 0 0",
               err, mem_read, mem_write);
    end
  endtask

  task automatic test_idle_ready();
    inject_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (wb_valid !== 1'b0 || err !== 1'b0 || mem_read !== 1'b0 || ex_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_ready[%0d]: got wbv=%b err=%b rd=%b ready=%b, required 0 0 0 1",
                 i, wb_valid, err, mem_read, ex_ready);
      end
    end
    inject_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    wait_n = 1000;
    issue(1'b1, 1'b0, 32'd6, 32'd0, 6'd8);
    step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (mem_read !== 1'b0 || stall !== 1'b0 || ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got rd=%b stall=%b ready=%b, required 0 0 1",
               mem_read, stall, ex_ready);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (wb_valid !== 1'b0 || err !== 1'b0 || ex_ready !== 1'b1 || mem_read !== 1'b0) begin
        errors++;
        $display("FAIL reset_after[%0d]: got wbv=%b err=%b ready=%b rd=%b, required 0 0 1 0",
                 i, wb_valid, err, ex_ready, mem_read);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end
    rst          = 1'b1;
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_addr      = '0;
    ex_wdata     = '0;
    ex_rd        = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_nonmem();
    test_store_load();
    test_wait_states();
    test_timeout();
    test_illegal();
    test_idle_ready();
    test_reset_mid();
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending writebacks, required 0", exp_q.size());
    end
    checks++;
    if (err_seen != exp_err) begin
      errors++;
      $display("FAIL err_count: got %0d err pulses, required %0d", err_seen, exp_err);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
